// File: rtl/trg_dead_time_ctrl_pkg.sv
// rtl/trg_dead_time_ctrl_pkg.sv - shared types and constants for the trigger dead-time controller
package trg_dead_time_ctrl_pkg;

  localparam int CLK_PER_10US_DEF = 500;
  localparam int TAG_W            = 5;
  localparam int DT_W             = 8;
  localparam int CNT_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PULSE     = 2'd1,
    ST_DEAD      = 2'd2,
    ST_WAIT_BUSY = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trg_dead_time_ctrl_if.sv
// rtl/trg_dead_time_ctrl_if.sv - trigger, control and status signal bundle
interface trg_dead_time_ctrl_if;
  import trg_dead_time_ctrl_pkg::*;

  logic              coincid_trg_in;
  logic [TAG_W-1:0]  coincid_tag_in;
  logic              busy_in;
  logic              trg_enable_in;
  logic [DT_W-1:0]   trg_dead_time_in;
  logic              cnt_clr_in;
  logic              trg_out;
  logic [TAG_W-1:0]  trg_tag_out;
  logic              dead_out;
  logic [CNT_W-1:0]  trg_acc_cnt_out;
  logic [CNT_W-1:0]  trg_veto_cnt_out;

  modport master (
    output coincid_trg_in, coincid_tag_in, busy_in, trg_enable_in, trg_dead_time_in, cnt_clr_in,
    input  trg_out, trg_tag_out, dead_out, trg_acc_cnt_out, trg_veto_cnt_out
  );

  modport slave (
    input  coincid_trg_in, coincid_tag_in, busy_in, trg_enable_in, trg_dead_time_in, cnt_clr_in,
    output trg_out, trg_tag_out, dead_out, trg_acc_cnt_out, trg_veto_cnt_out
  );

endinterface

// File: rtl/trg_dead_time_ctrl_tick_gen_10us.sv
// rtl/trg_dead_time_ctrl_tick_gen_10us.sv - 10 us prescaler with synchronous restart
module tick_gen_10us
  import trg_dead_time_ctrl_pkg::*;
#(
  parameter int CLK_PER_10US = CLK_PER_10US_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_PER_10US > 1) ? $clog2(CLK_PER_10US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_10US - 1);

  logic [CW-1:0] cnt;

  // Restart lands the counter at 0 for the first cycle after it, so a tick
  // comes exactly CLK_PER_10US cycles after restart deasserts.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/trg_dead_time_ctrl.sv
// rtl/trg_dead_time_ctrl.sv - accepts coincidence triggers, emits fixed pulses, enforces dead time
module trg_dead_time_ctrl
  import trg_dead_time_ctrl_pkg::*;
#(
  parameter int CLK_PER_10US  = CLK_PER_10US_DEF,
  parameter int TRG_PULSE_CYC = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  trg_dead_time_ctrl_if.slave   bus
);

  localparam logic [3:0] PULSE_LAST = 4'(TRG_PULSE_CYC - 1);

  state_t            state_q, state_d;
  logic              trg_r0, trg_r1;
  logic              trg_event, accept, veto, restart, tick;
  logic [3:0]        pulse_cnt_q, pulse_cnt_d;
  logic [DT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DT_W-1:0]   dt_q;
  logic [TAG_W-1:0]  tag_q;
  logic              trg_q, dead_q;
  logic [CNT_W-1:0]  acc_cnt, veto_cnt;

  assign trg_event = trg_r0 & ~trg_r1;
  assign accept    = trg_event & bus.trg_enable_in & (state_q == ST_IDLE) & ~bus.busy_in;
  assign veto      = trg_event & bus.trg_enable_in & ~accept;
  assign restart   = (state_q == ST_PULSE) && (state_d == ST_DEAD);

  tick_gen_10us #(.CLK_PER_10US(CLK_PER_10US)) u_tick (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      trg_r0      <= 1'b0;
      trg_r1      <= 1'b0;
      state_q     <= ST_IDLE;
      pulse_cnt_q <= '0;
      tick_cnt_q  <= '0;
      dt_q        <= '0;
      tag_q       <= '0;
      trg_q       <= 1'b0;
      dead_q      <= 1'b0;
    end else begin
      trg_r0      <= bus.coincid_trg_in;
      trg_r1      <= trg_r0;
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      // Outputs are registered from next state so they are glitch-free yet align with the state.
      trg_q       <= (state_d == ST_PULSE);
      dead_q      <= (state_d != ST_IDLE);
      if (accept) begin
        dt_q  <= bus.trg_dead_time_in;
        tag_q <= bus.coincid_tag_in;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_PULSE;
          pulse_cnt_d = '0;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d    = (dt_q != '0) ? ST_DEAD : ST_WAIT_BUSY;
          tick_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      ST_DEAD: begin
        if (tick) begin
          if (tick_cnt_q == dt_q - 8'd1) begin
            state_d = ST_WAIT_BUSY;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_BUSY: begin
        if (!bus.busy_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_cnt <= '0;
    end else if (bus.cnt_clr_in) begin
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= sat_inc(acc_cnt);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      veto_cnt <= '0;
    end else if (bus.cnt_clr_in) begin
      veto_cnt <= '0;
    end else if (veto) begin
      veto_cnt <= sat_inc(veto_cnt);
    end
  end

  assign bus.trg_out          = trg_q;
  assign bus.dead_out         = dead_q;
  assign bus.trg_tag_out      = tag_q;
  assign bus.trg_acc_cnt_out  = acc_cnt;
  assign bus.trg_veto_cnt_out = veto_cnt;

endmodule

// File: tb/tb_trg_dead_time_ctrl.sv
// tb/tb_trg_dead_time_ctrl.sv - directed self-checking bench for trg_dead_time_ctrl
module tb_trg_dead_time_ctrl;

  logic clk;
  logic rst;
  int   pass_cnt  = 0;
  int   check_cnt = 0;

  trg_dead_time_ctrl_if bus ();

  trg_dead_time_ctrl #(.CLK_PER_10US(500), .TRG_PULSE_CYC(5)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic trigger(input logic [4:0] tag, input logic clr);
    bus.coincid_trg_in = 1'b1;
    bus.coincid_tag_in = tag;
    @(negedge clk);
    bus.coincid_trg_in = 1'b0;
    bus.cnt_clr_in     = clr;
    @(negedge clk);
    bus.cnt_clr_in     = 1'b0;
  endtask

  task automatic clear_counters();
    bus.cnt_clr_in = 1'b1;
    @(negedge clk);
    bus.cnt_clr_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic measure(output int t_hi, output int d_hi);
    int n;
    t_hi = 0;
    d_hi = 0;
    n    = 0;
    while (bus.dead_out === 1'b1 && n < 5000) begin
      if (bus.trg_out === 1'b1) t_hi++;
      d_hi++;
      n++;
      @(negedge clk);
    end
    if (n >= 5000) d_hi = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    check_cnt++;
    if (bus.dead_out !== 1'b0) $display("FAIL reset_dead: got %0b expected 0", bus.dead_out); else pass_cnt++;
    check_cnt++;
    if (bus.trg_out !== 1'b0) $display("FAIL reset_trg: got %0b expected 0", bus.trg_out); else pass_cnt++;
    rst = 1'b0;
    wait_cycles(2);
    check_cnt++;
    if (bus.trg_tag_out !== 5'h00) $display("FAIL reset_tag: got %0h expected 0", bus.trg_tag_out); else pass_cnt++;
    check_cnt++;
    if (bus.trg_acc_cnt_out !== 16'h0) $display("FAIL reset_acc: got %0h expected 0", bus.trg_acc_cnt_out); else pass_cnt++;
    check_cnt++;
    if (bus.trg_veto_cnt_out !== 16'h0) $display("FAIL reset_veto: got %0h expected 0", bus.trg_veto_cnt_out); else pass_cnt++;
  endtask

  task automatic test_single();
    int t_hi, d_hi;
    bus.trg_dead_time_in = 8'd2;
    bus.coincid_trg_in   = 1'b1;
    bus.coincid_tag_in   = 5'h03;
    @(negedge clk);
    check_cnt++;
    if (bus.trg_out !== 1'b0) $display("FAIL single_latency_early: got %0b expected 0", bus.trg_out); else pass_cnt++;
    bus.coincid_trg_in = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (bus.trg_out !== 1'b1 || bus.dead_out !== 1'b1)
      $display("FAIL single_latency: got trg=%0b dead=%0b expected 1/1", bus.trg_out, bus.dead_out);
    else pass_cnt++;
    check_cnt++;
    if (bus.trg_tag_out !== 5'h03) $display("FAIL single_tag: got %0h expected 03", bus.trg_tag_out); else pass_cnt++;
    measure(t_hi, d_hi);
    check_cnt++;
    if (t_hi !== 5) $display("FAIL single_pulse_len: got %0d expected 5", t_hi); else pass_cnt++;
    check_cnt++;
    if (d_hi !== 1006) $display("FAIL single_dead_len: got %0d expected 1006", d_hi); else pass_cnt++;
    check_cnt++;
    if (bus.trg_acc_cnt_out !== 16'd1 || bus.trg_veto_cnt_out !== 16'd0)
      $display("FAIL single_counts: got acc=%0d veto=%0d expected 1/0", bus.trg_acc_cnt_out, bus.trg_veto_cnt_out);
    else pass_cnt++;
  endtask

  task automatic test_veto();
    int t_hi, d_hi;
    clear_counters();
    bus.trg_dead_time_in = 8'd2;
    trigger(5'h05, 1'b0);
    wait_cycles(148);
    bus.trg_dead_time_in = 8'd0;
    trigger(5'h06, 1'b0);
    check_cnt++;
    if (bus.trg_out !== 1'b0 || bus.dead_out !== 1'b1)
      $display("FAIL veto_no_pulse: got trg=%0b dead=%0b expected 0/1", bus.trg_out, bus.dead_out);
    else pass_cnt++;
    check_cnt++;
    if (bus.trg_veto_cnt_out !== 16'd1 || bus.trg_acc_cnt_out !== 16'd1)
      $display("FAIL veto_counts: got acc=%0d veto=%0d expected 1/1", bus.trg_acc_cnt_out, bus.trg_veto_cnt_out);
    else pass_cnt++;
    check_cnt++;
    if (bus.trg_tag_out !== 5'h05) $display("FAIL veto_tag_held: got %0h expected 05", bus.trg_tag_out); else pass_cnt++;
    wait_cycles(1098);
    bus.trg_dead_time_in = 8'd2;
    trigger(5'h07, 1'b0);
    check_cnt++;
    if (bus.trg_out !== 1'b1) $display("FAIL veto_rearm: got %0b expected 1", bus.trg_out); else pass_cnt++;
    measure(t_hi, d_hi);
    check_cnt++;
    if (d_hi !== 1006 || bus.trg_acc_cnt_out !== 16'd2)
      $display("FAIL veto_second_accept: got dead=%0d acc=%0d expected 1006/2", d_hi, bus.trg_acc_cnt_out);
    else pass_cnt++;
  endtask

  task automatic test_busy();
    int t_hi, d_hi;
    clear_counters();
    bus.trg_dead_time_in = 8'd1;
    trigger(5'h03, 1'b0);
    wait_cycles(248);
    bus.busy_in = 1'b1;
    wait_cycles(750);
    trigger(5'h04, 1'b0);
    check_cnt++;
    if (bus.trg_out !== 1'b0 || bus.dead_out !== 1'b1)
      $display("FAIL busy_veto_pulse: got trg=%0b dead=%0b expected 0/1", bus.trg_out, bus.dead_out);
    else pass_cnt++;
    wait_cycles(998);
    check_cnt++;
    if (bus.dead_out !== 1'b1) $display("FAIL busy_hold: got %0b expected 1", bus.dead_out); else pass_cnt++;
    bus.busy_in = 1'b0;
    wait_cycles(1);
    check_cnt++;
    if (bus.dead_out !== 1'b0) $display("FAIL busy_release: got %0b expected 0", bus.dead_out); else pass_cnt++;
    check_cnt++;
    if (bus.trg_acc_cnt_out !== 16'd1 || bus.trg_veto_cnt_out !== 16'd1)
      $display("FAIL busy_counts: got acc=%0d veto=%0d expected 1/1", bus.trg_acc_cnt_out, bus.trg_veto_cnt_out);
    else pass_cnt++;
    wait_cycles(99);
    trigger(5'h07, 1'b0);
    measure(t_hi, d_hi);
    check_cnt++;
    if (t_hi !== 5 || d_hi !== 506)
      $display("FAIL busy_after_accept: got trg=%0d dead=%0d expected 5/506", t_hi, d_hi);
    else pass_cnt++;
    bus.busy_in = 1'b1;
    trigger(5'h08, 1'b0);
    check_cnt++;
    if (bus.dead_out !== 1'b0 || bus.trg_veto_cnt_out !== 16'd2 || bus.trg_tag_out !== 5'h07)
      $display("FAIL busy_idle_veto: got dead=%0b veto=%0d tag=%0h expected 0/2/07",
               bus.dead_out, bus.trg_veto_cnt_out, bus.trg_tag_out);
    else pass_cnt++;
    bus.busy_in = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_back_to_back();
    int t_hi, d_hi, hi;
    clear_counters();
    bus.trg_dead_time_in = 8'd0;
    for (int i = 0; i < 4; i++) begin
      trigger(5'(i + 16), 1'b0);
      measure(t_hi, d_hi);
      check_cnt++;
      if (t_hi !== 5 || d_hi !== 6)
        $display("FAIL b2b_len_%0d: got trg=%0d dead=%0d expected 5/6", i, t_hi, d_hi);
      else pass_cnt++;
    end
    check_cnt++;
    if (bus.trg_acc_cnt_out !== 16'd4 || bus.trg_veto_cnt_out !== 16'd0 || bus.trg_tag_out !== 5'h13)
      $display("FAIL b2b_counts: got acc=%0d veto=%0d tag=%0h expected 4/0/13",
               bus.trg_acc_cnt_out, bus.trg_veto_cnt_out, bus.trg_tag_out);
    else pass_cnt++;
    bus.trg_enable_in = 1'b0;
    trigger(5'h1A, 1'b0);
    trigger(5'h1B, 1'b0);
    check_cnt++;
    if (bus.dead_out !== 1'b0 || bus.trg_acc_cnt_out !== 16'd4 || bus.trg_veto_cnt_out !== 16'd0)
      $display("FAIL disabled: got dead=%0b acc=%0d veto=%0d expected 0/4/0",
               bus.dead_out, bus.trg_acc_cnt_out, bus.trg_veto_cnt_out);
    else pass_cnt++;
    bus.trg_enable_in = 1'b1;
    wait_cycles(2);
    hi = 0;
    bus.coincid_trg_in = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.trg_out === 1'b1) hi++;
    end
    bus.coincid_trg_in = 1'b0;
    wait_cycles(2);
    check_cnt++;
    if (hi !== 5 || bus.trg_acc_cnt_out !== 16'd5 || bus.trg_veto_cnt_out !== 16'd0)
      $display("FAIL level_single_event: got hi=%0d acc=%0d veto=%0d expected 5/5/0",
               hi, bus.trg_acc_cnt_out, bus.trg_veto_cnt_out);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int t_hi, d_hi;
    bus.trg_dead_time_in = 8'd0;
    force dut.acc_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.acc_cnt;
    trigger(5'h0A, 1'b0);
    measure(t_hi, d_hi);
    check_cnt++;
    if (bus.trg_acc_cnt_out !== 16'hFFFF) $display("FAIL sat_reach: got %0h expected ffff", bus.trg_acc_cnt_out); else pass_cnt++;
    trigger(5'h0B, 1'b0);
    measure(t_hi, d_hi);
    check_cnt++;
    if (bus.trg_acc_cnt_out !== 16'hFFFF) $display("FAIL sat_hold: got %0h expected ffff", bus.trg_acc_cnt_out); else pass_cnt++;
    force dut.veto_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.veto_cnt;
    bus.busy_in = 1'b1;
    trigger(5'h0C, 1'b0);
    bus.busy_in = 1'b0;
    check_cnt++;
    if (bus.trg_veto_cnt_out !== 16'hFFFF) $display("FAIL sat_veto: got %0h expected ffff", bus.trg_veto_cnt_out); else pass_cnt++;
    trigger(5'h0D, 1'b1);
    check_cnt++;
    if (bus.trg_out !== 1'b1 || bus.trg_acc_cnt_out !== 16'h0 || bus.trg_veto_cnt_out !== 16'h0)
      $display("FAIL clr_with_accept: got trg=%0b acc=%0h veto=%0h expected 1/0/0",
               bus.trg_out, bus.trg_acc_cnt_out, bus.trg_veto_cnt_out);
    else pass_cnt++;
    measure(t_hi, d_hi);
    bus.busy_in = 1'b1;
    trigger(5'h0E, 1'b0);
    check_cnt++;
    if (bus.trg_veto_cnt_out !== 16'd1) $display("FAIL veto_after_clr: got %0d expected 1", bus.trg_veto_cnt_out); else pass_cnt++;
    trigger(5'h0F, 1'b1);
    bus.busy_in = 1'b0;
    check_cnt++;
    if (bus.trg_veto_cnt_out !== 16'd0 || bus.trg_acc_cnt_out !== 16'd0)
      $display("FAIL clr_with_veto: got acc=%0h veto=%0h expected 0/0", bus.trg_acc_cnt_out, bus.trg_veto_cnt_out);
    else pass_cnt++;
    wait_cycles(2);
  endtask

  task automatic test_reset_mid_dead();
    int t_hi, d_hi;
    clear_counters();
    bus.trg_dead_time_in = 8'd2;
    trigger(5'h11, 1'b0);
    wait_cycles(100);
    check_cnt++;
    if (bus.dead_out !== 1'b1 || bus.trg_acc_cnt_out !== 16'd1)
      $display("FAIL pre_reset: got dead=%0b acc=%0d expected 1/1", bus.dead_out, bus.trg_acc_cnt_out);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    check_cnt++;
    if (bus.dead_out !== 1'b0 || bus.trg_out !== 1'b0 || bus.trg_acc_cnt_out !== 16'd0 || bus.trg_tag_out !== 5'h00)
      $display("FAIL async_reset: got dead=%0b trg=%0b acc=%0d tag=%0h expected 0/0/0/00",
               bus.dead_out, bus.trg_out, bus.trg_acc_cnt_out, bus.trg_tag_out);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    trigger(5'h12, 1'b0);
    measure(t_hi, d_hi);
    check_cnt++;
    if (t_hi !== 5 || d_hi !== 1006 || bus.trg_acc_cnt_out !== 16'd1 || bus.trg_tag_out !== 5'h12)
      $display("FAIL post_reset_accept: got trg=%0d dead=%0d acc=%0d tag=%0h expected 5/1006/1/12",
               t_hi, d_hi, bus.trg_acc_cnt_out, bus.trg_tag_out);
    else pass_cnt++;
  endtask

  initial begin
    rst                  = 1'b1;
    bus.coincid_trg_in   = 1'b0;
    bus.coincid_tag_in   = 5'h00;
    bus.busy_in          = 1'b0;
    bus.trg_enable_in    = 1'b1;
    bus.trg_dead_time_in = 8'd2;
    bus.cnt_clr_in       = 1'b0;
    test_reset();
    test_single();
    test_veto();
    test_busy();
    test_back_to_back();
    test_saturation();
    test_reset_mid_dead();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
